control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle RV32I control unit for the fewcore datapath. It fetches an instruction, decodes it into the 12-bit `operation` code plus operands for the registered ALU, and sequences memory access and register writeback. It owns the PC and the instruction register. It sits between instruction/data memory, the register file and the ALU.

## Interface

Parameters:
- `XLEN`, 32, datapath width.
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, held until accepted.
- `imem_addr`  out  XLEN  fetch address (= pc).
- `imem_ready`  in  1  fetch accepted; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `rs1_addr`, `rs2_addr`  out  5  register-file read addresses. Reads are combinational.
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data.
- `rd_addr`  out  5  writeback address.
- `rd_we`  out  1  one-cycle write strobe.
- `rd_wdata`  out  XLEN  writeback data.
- `operation`  out  12  ALU op code.
- `opr1`, `opr2`  out  XLEN  ALU operands.
- `pc`  out  XLEN  current PC, also fed to the ALU.
- `alu_out`  in  XLEN  ALU result, registered by the ALU, valid one cycle after its inputs.
- `zero`  in  1  branch-taken flag from the ALU.
- `dmem_req`  out  1  data request, held until `dmem_ready`.
- `dmem_we`  out  1  1 = store.
- `dmem_be`  out  4  store byte enables.
- `dmem_addr`  out  XLEN  word-aligned address (`alu_out & ~3`).
- `dmem_wdata`  out  32  store data, shifted to the byte lane.
- `dmem_ready`  in  1  access done; `dmem_rdata` valid in the same cycle.
- `dmem_rdata`  in  32  load data.
- `illegal`  out  1  sticky flag for an unsupported opcode or a misaligned access.

## Operation

- **Operation encoding:** `operation = {b11, b10, funct3, opcode}`.
  - `b11 = instr[30]` for OP (0110011) only.
  - `b10 = instr[30]` for OP-IMM with funct3 = 101 only.
  - For LUI, AUIPC and JAL, the funct3 field is forced to 000.
  - All other unused bits are 0.
- **Operands:**
  - `opr1 = rs1_data`, except `opr1 = pc` for AUIPC.
  - `opr2 = rs2_data` for OP and BRANCH; otherwise the sign-extended I, S or U immediate.
- **States:**
  - RESET → FETCH.
  - FETCH: `imem_req = 1`. On `imem_ready`, latch IR and go to DECODE.
  - DECODE: drive `rs1_addr`/`rs2_addr` from IR and build the immediate. Go to HALT if the opcode is unsupported, else EXECUTE.
  - EXECUTE: drive `operation`/`opr1`/`opr2` to the ALU (the ALU samples them on this edge). Go to RESULT.
  - RESULT: `alu_out` and `zero` are valid here.
    - BRANCH: if `zero` = 1, pc ← pc + immB, else pc ← pc + 4. Go to FETCH.
    - LOAD/STORE: go to HALT if misaligned (halfword with `addr[0] = 1`, or word with `addr[1:0] ≠ 0`), else MEM.
    - All others: go to WRITEBACK.
  - MEM: hold `dmem_req`/`dmem_we`/`dmem_be`/`dmem_addr`/`dmem_wdata` stable until `dmem_ready`.
    - Store: pc ← pc + 4, then FETCH.
    - Load: latch the extracted, sign- or zero-extended data (LB/LH/LW/LBU/LHU), then WRITEBACK.
  - WRITEBACK: pulse `rd_we` for one cycle. `rd_wdata` is:
    - load data for loads;
    - immU for LUI;
    - `alu_out` otherwise (for JAL/JALR, `alu_out` is the link address pc + 4).
  - PC update in WRITEBACK:
    - JAL: pc ← pc + immJ.
    - JALR: pc ← (rs1_data + immI) & ~1, with rs1 held from DECODE.
    - All others: pc ← pc + 4.
  - Then FETCH.
  - HALT: `illegal = 1`. Remains in HALT until reset.
- **x0 writes:** `rd_we` is suppressed when `rd = 0`.
- **Address arithmetic:** all PC arithmetic is modulo 2^XLEN. Wrap-around at 32'hFFFF_FFFC → 0 is legal.

## Timing

- **Reset values:** pc = `RESET_PC`, state = FETCH, IR = 0, and the following outputs are 0: `imem_req`, `dmem_req`, `dmem_we`, `dmem_be`, `rd_we`, `operation`, `opr1`, `opr2`, `illegal`.
- **Cycles per instruction with zero-wait memory:**
  - ALU/LUI/AUIPC/JAL/JALR: 5.
  - Branch: 4.
  - Store: 5.
  - Load: 6.
- Each memory wait cycle adds one cycle.
- **Handshake:** request outputs do not change while a request is pending without ready.
- **Reset mid-operation:** asserting `rst_n` low mid-transaction drops `imem_req`/`dmem_req` immediately; no writeback occurs.

## Structure

- **Package `fewcore_pkg`:**
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - the state enum;
  - the `operation` field positions.
- **Sub-module `imm_gen`:** combinational I/S/B/U/J immediate extraction and sign extension from IR.

## Test plan

- Reset with `RESET_PC` = 0x100 → `imem_addr` = 0x100, `imem_req` = 1 in the first cycle after release, all other outputs 0.
- Fetch `sub x3,x1,x2` (0x402081B3) with x1 = 9, x2 = 4 → `operation` = 12'b100000110011; ALU model returns 5; `rd_we` pulse with `rd_addr` = 3, `rd_wdata` = 5; the next fetch is at pc + 4; 5 cycles total.
- `beq` with immB = −8 at pc = 0x20, `zero` = 1 → next fetch at 0x18. With `zero` = 0 → next fetch at 0x24. Neither case pulses `rd_we`.
- `lb` at address 0x103 with `dmem_rdata` = 0x80000000, `dmem_ready` delayed 3 cycles → `dmem_req` held stable for those cycles, `dmem_addr` = 0x100, `rd_wdata` = 0xFFFFFF80.
- `sh` to 0x202 with rs2 = 0x1234 → `dmem_be` = 4'b1100, `dmem_wdata` = 0x12340000. `lw` from 0x202 → `illegal` = 1, FSM stays in HALT, and `imem_req` stays 0 until reset.
- `jalr x1,8(x5)` with x5 = 0x1001 at pc = 0x40 → x1 = 0x44, next fetch at 0x1008. The same instruction with rd = x0 → no `rd_we` pulse.

Source files
------------

// File: rtl/fewcore_pkg.sv
// fewcore_pkg: shared definitions for the fewcore control unit.
//   - RV32I opcode constants for the supported instruction classes
//   - control FSM state enum
//   - bit positions of the fields inside the 12-bit ALU operation code
//   - small decode helpers used by the control unit
package fewcore_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_RESULT,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_e;

  // operation = {b11, b10, funct3, opcode}
  localparam int OPN_OPCODE_LSB = 0;
  localparam int OPN_FUNCT3_LSB = 7;
  localparam int OPN_B10        = 10;
  localparam int OPN_B11        = 11;

  function automatic logic is_supported(input logic [6:0] opc);
    return (opc == OPC_OP)    || (opc == OPC_OP_IMM) || (opc == OPC_LOAD)  ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL)   ||
           (opc == OPC_JALR)  || (opc == OPC_LUI)    || (opc == OPC_AUIPC);
  endfunction

  function automatic logic [11:0] encode_operation(input logic [31:0] ir);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [11:0] op;
    opc = ir[6:0];
    f3  = ir[14:12];
    op  = '0;
    op[OPN_OPCODE_LSB +: 7] = opc;
    // U/J formats carry no funct3; those bits belong to the immediate.
    if (opc != OPC_LUI && opc != OPC_AUIPC && opc != OPC_JAL)
      op[OPN_FUNCT3_LSB +: 3] = f3;
    // instr[30] selects SRA/SRAI vs SRL/SRLI and SUB vs ADD.
    op[OPN_B10] = (opc == OPC_OP_IMM) && (f3 == 3'b101) && ir[30];
    op[OPN_B11] = (opc == OPC_OP) && ir[30];
    return op;
  endfunction

  // funct3[1:0]: 00 byte, 01 halfword, 1x word.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_imm_gen.sv
// imm_gen: combinational immediate extraction from the instruction register.
// Ports:
//   ir     in   32    instruction word
//   imm_i  out  XLEN  sign-extended I-type immediate
//   imm_s  out  XLEN  sign-extended S-type immediate
//   imm_b  out  XLEN  sign-extended B-type immediate (byte offset)
//   imm_u  out  XLEN  U-type immediate (upper 20 bits, low 12 zero)
//   imm_j  out  XLEN  sign-extended J-type immediate (byte offset)
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_s,
  output logic [XLEN-1:0] imm_b,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j
);

  logic signed [31:0] i32, s32, b32, u32, j32;

  assign i32 = {{20{ir[31]}}, ir[31:20]};
  assign s32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign b32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign u32 = {ir[31:12], 12'b0};
  assign j32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  // Signed sources, so widening to XLEN sign-extends.
  assign imm_i = XLEN'(i32);
  assign imm_s = XLEN'(s32);
  assign imm_b = XLEN'(b32);
  assign imm_u = XLEN'(u32);
  assign imm_j = XLEN'(j32);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I sequencer for the fewcore datapath.
// Fetches into the IR, decodes to an ALU operation + operands, sequences
// data-memory access and register writeback, and owns the PC.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata       instruction fetch handshake
//   rs1_addr/rs2_addr, rs1/2_data   combinational register-file reads
//   rd_addr/rd_we/rd_wdata          register-file write (one-cycle strobe)
//   operation/opr1/opr2, pc         ALU inputs (sampled at end of EXECUTE)
//   alu_out, zero                   registered ALU result, valid in RESULT
//   dmem_req/we/be/addr/wdata       data-memory request, held until ready
//   dmem_ready/rdata                data-memory completion
//   illegal                         sticky: unsupported opcode/misaligned
module control_unit
  import fewcore_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic [XLEN-1:0] rd_wdata,
  output logic [11:0]     operation,
  output logic [XLEN-1:0] opr1,
  output logic [XLEN-1:0] opr2,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] alu_out,
  input  logic            zero,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_addr,
  output logic [31:0]     dmem_wdata,
  input  logic            dmem_ready,
  input  logic [31:0]     dmem_rdata,
  output logic            illegal
);

  state_e state_q, state_d;

  logic [XLEN-1:0] pc_q;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] alu_q;       // ALU result captured in RESULT
  logic [XLEN-1:0] load_q;      // extended load data
  logic [XLEN-1:0] mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [3:0]      mem_be_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign rd     = ir_q[11:7];

  logic is_op, is_branch, is_load, is_store, is_jal, is_jalr, is_lui, is_auipc;

  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir    (ir_q),
    .imm_i (imm_i),
    .imm_s (imm_s),
    .imm_b (imm_b),
    .imm_u (imm_u),
    .imm_j (imm_j)
  );

  // PC arithmetic wraps naturally at XLEN bits.
  logic [XLEN-1:0] pc_plus4, pc_branch, pc_jal, jalr_sum, jalr_target;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign pc_branch   = pc_q + imm_b;
  assign pc_jal      = pc_q + imm_j;
  assign jalr_sum    = rs1_data + imm_i;
  assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

  logic misaligned;
  assign misaligned = access_misaligned(funct3, alu_out[1:0]);

  // Store byte enables and lane-shifted data, from the address in RESULT.
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [4:0]  st_shift;

  assign st_shift = {alu_out[1:0], 3'b000};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    st_be   = 4'b0000;
    st_data = '0;
    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << alu_out[1:0];
        st_data = 32'(rs2_data[7:0]) << st_shift;
      end
      2'b01: begin
        st_be   = 4'b0011 << alu_out[1:0];
        st_data = 32'(rs2_data[15:0]) << st_shift;
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_data[31:0];
      end
    endcase
  end

  // Load data extraction; the byte offset was captured with alu_q.
  logic [31:0]     ld_shifted;
  logic [XLEN-1:0] ld_value;

  assign ld_shifted = dmem_rdata >> {alu_q[1:0], 3'b000};

  always_comb begin
    ld_value = '0;
    case (funct3)
      3'b000:  ld_value = XLEN'($signed(ld_shifted[7:0]));
      3'b001:  ld_value = XLEN'($signed(ld_shifted[15:0]));
      3'b100:  ld_value = XLEN'(ld_shifted[7:0]);
      3'b101:  ld_value = XLEN'(ld_shifted[15:0]);
      default: ld_value = XLEN'($signed(ld_shifted));
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (imem_ready) state_d = S_DECODE;
      S_DECODE:    state_d = is_supported(opcode) ? S_EXECUTE : S_HALT;
      S_EXECUTE:   state_d = S_RESULT;
      S_RESULT: begin
        if (is_branch)                state_d = S_FETCH;
        else if (is_load || is_store) state_d = misaligned ? S_HALT : S_MEM;
        else                          state_d = S_WRITEBACK;
      end
      S_MEM:       if (dmem_ready) state_d = is_store ? S_FETCH : S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: if (imem_ready) ir_q <= imem_rdata;
        S_RESULT: begin
          // The ALU re-samples every cycle, so its result is kept here for
          // the MEM and WRITEBACK states.
          alu_q       <= alu_out;
          mem_addr_q  <= {alu_out[XLEN-1:2], 2'b00};
          mem_wdata_q <= st_data;
          mem_be_q    <= st_be;
          if (is_branch) pc_q <= zero ? pc_branch : pc_plus4;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (is_store) pc_q   <= pc_plus4;
            else          load_q <= ld_value;
          end
        end
        S_WRITEBACK: begin
          if (is_jal)       pc_q <= pc_jal;
          else if (is_jalr) pc_q <= jalr_target;
          else              pc_q <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

  // ALU drive: only meaningful in EXECUTE, zero elsewhere.
  always_comb begin
    operation = '0;
    opr1      = '0;
    opr2      = '0;
    if (state_q == S_EXECUTE) begin
      operation = encode_operation(ir_q);
      opr1      = is_auipc ? pc_q : rs1_data;
      if (is_op || is_branch)    opr2 = rs2_data;
      else if (is_store)         opr2 = imm_s;
      else if (is_lui || is_auipc) opr2 = imm_u;
      else                       opr2 = imm_i;
    end
  end

  always_comb begin
    rd_wdata = alu_q;
    if (is_load)     rd_wdata = load_q;
    else if (is_lui) rd_wdata = imm_u;
  end

  // rst_n gates the fetch request so it drops the instant reset asserts,
  // even though the reset state is FETCH.
  assign imem_req   = rst_n && (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;

  assign rs1_addr   = ir_q[19:15];
  assign rs2_addr   = ir_q[24:20];
  assign rd_addr    = rd;
  assign rd_we      = (state_q == S_WRITEBACK) && (rd != 5'd0);

  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && is_store;
  assign dmem_be    = dmem_we ? mem_be_q : 4'b0000;
  assign dmem_addr  = mem_addr_q;
  assign dmem_wdata = mem_wdata_q;

  assign illegal    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench for control_unit. Memories, register
// file and a registered ALU are modelled here; expected fetch, writeback and
// data-memory events are queued up front and a negedge monitor compares
// each event the DUT presents against the queue head.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_wdata;
  logic        rd_we;
  logic [11:0] operation;
  logic [31:0] opr1, opr2, pc, alu_out;
  logic        zero;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        illegal;

  always #5 clk = ~clk;

  control_unit #(.XLEN(32), .RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_addr(rd_addr), .rd_we(rd_we), .rd_wdata(rd_wdata),
    .operation(operation), .opr1(opr1), .opr2(opr2), .pc(pc),
    .alu_out(alu_out), .zero(zero),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .illegal(illegal)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- environment models ----------------
  logic [31:0] imem [0:4095];
  logic        imem_stall = 1'b0;

  assign imem_ready = imem_req && !imem_stall;
  assign imem_rdata = imem[imem_addr[13:2]];

  logic [31:0] regs [0:31];
  assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd9;
      regs[2] <= 32'd4;
      regs[5] <= 32'h0000_1001;
      regs[6] <= 32'd1;
      regs[7] <= 32'd2;
      regs[9] <= 32'h0000_1234;
    end else if (rd_we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_wdata;
    end
  end

  // Registered ALU: result valid the cycle after its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out <= 32'd0;
      zero    <= 1'b0;
    end else begin
      zero <= 1'b0;
      case (operation[6:0])
        7'b0110011: alu_out <= operation[11] ? opr1 - opr2 : opr1 + opr2;
        7'b0010011, 7'b0010111, 7'b0000011, 7'b0100011:
                    alu_out <= opr1 + opr2;
        7'b0110111: alu_out <= opr2;
        7'b1101111, 7'b1100111: alu_out <= pc + 32'd4;
        7'b1100011: begin
          alu_out <= 32'd0;
          zero    <= (operation[9:7] == 3'b000) && (opr1 == opr2);
        end
        default:    alu_out <= 32'd0;
      endcase
    end
  end

  // Data memory: loads take 3 wait cycles, stores none.
  int dcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      dcnt <= 0;
    else if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
    else                             dcnt <= 0;
  end
  assign dmem_ready = dmem_req && (dcnt == (dmem_we ? 0 : 3));
  assign dmem_rdata = 32'h8000_0000;

  // ---------------- scoreboard ----------------
  typedef enum int {EV_FETCH = 0, EV_WB = 1, EV_DMEM = 2} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
    int          delta;
  } ev_t;

  ev_t exp_q[$];

  function automatic void push_ev(input ev_kind_e k, input logic [31:0] a,
                                  input logic [31:0] d, input logic [3:0] be,
                                  input logic we, input int delta);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.be = be; e.we = we; e.delta = delta;
    exp_q.push_back(e);
  endfunction

  task automatic observe(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: kind %0d addr 0x%08h, expected none",
               got.kind, got.addr);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(got.kind), 32'(e.kind));
      case (e.kind)
        EV_FETCH: begin
          check("fetch_addr", got.addr, e.addr);
          if (e.delta != 0) check("fetch_cycles", 32'(got.delta), 32'(e.delta));
        end
        EV_WB: begin
          check("wb_rd", got.addr, e.addr);
          check("wb_data", got.data, e.data);
        end
        default: begin
          check("dmem_addr", got.addr, e.addr);
          check("dmem_we", 32'(got.we), 32'(e.we));
          if (e.we) begin
            check("dmem_be", 32'(got.be), 32'(e.be));
            check("dmem_wdata", got.data, e.data);
          end
        end
      endcase
    end
  endtask

  int          cyc = 0;
  int          last_fetch_cyc = 0;
  logic        have_op = 1'b0;
  logic [11:0] first_op;
  logic [31:0] first_opr1, first_opr2;
  logic        stab_prev = 1'b0;
  logic [31:0] stab_addr, stab_wdata;
  logic [3:0]  stab_be;
  logic        stab_we;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t g;
    if (rst_n) begin
      if (imem_req && imem_ready) begin
        g.kind = EV_FETCH; g.addr = imem_addr; g.data = 0; g.be = 0; g.we = 0;
        g.delta = cyc - last_fetch_cyc;
        last_fetch_cyc = cyc;
        observe(g);
      end
      if (rd_we) begin
        g.kind = EV_WB; g.addr = 32'(rd_addr); g.data = rd_wdata;
        g.be = 0; g.we = 0; g.delta = 0;
        observe(g);
      end
      if (dmem_req && dmem_ready) begin
        g.kind = EV_DMEM; g.addr = dmem_addr; g.data = dmem_wdata;
        g.be = dmem_be; g.we = dmem_we; g.delta = 0;
        observe(g);
      end
      if (stab_prev) begin
        check("dmem_req_held", 32'(dmem_req), 32'd1);
        check("dmem_addr_stable", dmem_addr, stab_addr);
        check("dmem_ctrl_stable", {27'd0, stab_we, stab_be}, {27'd0, dmem_we, dmem_be});
        check("dmem_wdata_stable", dmem_wdata, stab_wdata);
      end
      stab_prev  = dmem_req && !dmem_ready;
      stab_addr  = dmem_addr;
      stab_wdata = dmem_wdata;
      stab_be    = dmem_be;
      stab_we    = dmem_we;
      if (!have_op && operation != 12'd0) begin
        have_op    = 1'b1;
        first_op   = operation;
        first_opr1 = opr1;
        first_opr2 = opr2;
      end
    end else begin
      stab_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    imem[addr[13:2]] = word;
  endtask

  initial begin
    logic leak;
    for (int i = 0; i < 4096; i++) imem[i] = 32'd0;

    put(32'h100,  32'h402081B3);  // sub  x3,x1,x2
    put(32'h104,  32'h04000067);  // jalr x0,0x40(x0)
    put(32'h040,  32'h008280E7);  // jalr x1,8(x5)
    put(32'h1008, 32'h000022B7);  // lui  x5,0x2
    put(32'h100C, 32'h00828067);  // jalr x0,8(x5)
    put(32'h2008, 32'h02000067);  // jalr x0,0x20(x0)
    put(32'h020,  32'hFE730CE3);  // beq  x6,x7,-8
    put(32'h024,  32'h00100393);  // addi x7,x0,1
    put(32'h028,  32'hFF9FF56F);  // jal  x10,-8
    put(32'h018,  32'h30000067);  // jalr x0,0x300(x0)
    put(32'h300,  32'h10300403);  // lb   x8,0x103(x0)
    put(32'h304,  32'h20901123);  // sh   x9,0x202(x0)
    put(32'h308,  32'h00001597);  // auipc x11,1
    put(32'h30C,  32'h20202603);  // lw   x12,0x202(x0)  -> misaligned

    push_ev(EV_FETCH, 32'h100, 0, 0, 0, 0);
    push_ev(EV_WB,    32'd3, 32'd5, 0, 0, 0);
    push_ev(EV_FETCH, 32'h104, 0, 0, 0, 5);
    push_ev(EV_FETCH, 32'h040, 0, 0, 0, 5);
    push_ev(EV_WB,    32'd1, 32'h44, 0, 0, 0);
    push_ev(EV_FETCH, 32'h1008, 0, 0, 0, 5);
    push_ev(EV_WB,    32'd5, 32'h2000, 0, 0, 0);
    push_ev(EV_FETCH, 32'h100C, 0, 0, 0, 5);
    push_ev(EV_FETCH, 32'h2008, 0, 0, 0, 5);
    push_ev(EV_FETCH, 32'h020, 0, 0, 0, 5);
    push_ev(EV_FETCH, 32'h024, 0, 0, 0, 4);   // beq not taken
    push_ev(EV_WB,    32'd7, 32'd1, 0, 0, 0);
    push_ev(EV_FETCH, 32'h028, 0, 0, 0, 5);
    push_ev(EV_WB,    32'd10, 32'h2C, 0, 0, 0);
    push_ev(EV_FETCH, 32'h020, 0, 0, 0, 5);
    push_ev(EV_FETCH, 32'h018, 0, 0, 0, 4);   // beq taken
    push_ev(EV_FETCH, 32'h300, 0, 0, 0, 5);
    push_ev(EV_DMEM,  32'h100, 0, 4'b0000, 1'b0, 0);
    push_ev(EV_WB,    32'd8, 32'hFFFF_FF80, 0, 0, 0);
    push_ev(EV_FETCH, 32'h304, 0, 0, 0, 9);   // 6 + 3 wait cycles
    push_ev(EV_DMEM,  32'h200, 32'h1234_0000, 4'b1100, 1'b1, 0);
    push_ev(EV_FETCH, 32'h308, 0, 0, 0, 5);
    push_ev(EV_WB,    32'd11, 32'h1308, 0, 0, 0);
    push_ev(EV_FETCH, 32'h30C, 0, 0, 0, 5);

    repeat (3) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_imem_addr", imem_addr, 32'h100);
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_dmem", {29'd0, dmem_req, dmem_we, rd_we}, 32'd0);
    check("post_rst_dmem_be", 32'(dmem_be), 32'd0);
    check("post_rst_operation", 32'(operation), 32'd0);
    check("post_rst_opr1", opr1, 32'd0);
    check("post_rst_opr2", opr2, 32'd0);
    check("post_rst_illegal", 32'(illegal), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (illegal) break;
    end
    check("halt_reached", 32'(illegal), 32'd1);

    leak = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req || !illegal) leak = 1'b1;
    end
    check("halt_holds", 32'(leak), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("sub_operation", 32'(first_op), 32'h833);
    check("sub_opr1", first_opr1, 32'd9);
    check("sub_opr2", first_opr2, 32'd4);

    // Reset out of HALT, then hold a fetch pending and reset mid-request.
    imem_stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_illegal", 32'(illegal), 32'd0);
    check("rst2_imem_req", 32'(imem_req), 32'd0);
    check("rst2_pc", pc, 32'h100);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rel2_imem_req", 32'(imem_req), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("fetch_req_held", 32'(imem_req), 32'd1);
      check("fetch_addr_held", imem_addr, 32'h100);
    end
    #2 rst_n = 1'b0;
    #1;
    check("reset_drops_req", 32'(imem_req), 32'd0);
    check("reset_no_we", 32'(rd_we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
